// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer_if
// Brief    : Redirect / stall / imem handshake bundle for the fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_fetch_sequencer_if;
    logic        stall;
    logic        Ctrl_jump;
    logic [31:0] jumpToWhere;
    logic        Ctrl_branch;
    logic [31:0] branchToWhere;
    logic        imem_ready;
    logic [31:0] pc_cur;
    logic        pc_valid;
    logic        flush;
    logic        addr_err;
    logic [31:0] fetch_count;

    // Sequencer side: owns the PC and drives the fetch request.
    modport master (
        input  stall, Ctrl_jump, jumpToWhere, Ctrl_branch, branchToWhere, imem_ready,
        output pc_cur, pc_valid, flush, addr_err, fetch_count
    );

    // Pipeline / imem side.
    modport slave (
        output stall, Ctrl_jump, jumpToWhere, Ctrl_branch, branchToWhere, imem_ready,
        input  pc_cur, pc_valid, flush, addr_err, fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer
// Brief    : Fetch PC owner. Arbitrates jump > branch > sequential advance,
//            honours stall / imem back-pressure, pulses IF/ID flush after
//            every redirect and counts accepted fetches.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_3000,
    parameter int          FLUSH_CYCLES = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    pc_fetch_sequencer_if.master fetch
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Counter is preloaded so that it reaches zero on the last flush cycle.
    localparam logic [2:0] c_flush_load = 3'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_flush_cnt;
    logic [2:0]  w_flush_cnt_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_fetch_count;
    logic        r_pc_valid;
    logic        r_flush;
    logic        r_addr_err;

    logic        w_active;
    logic        w_accept;
    logic        w_redirect;
    logic [31:0] w_target;

    // Requests are only honoured once the sequencer has left BOOT.
    assign w_active   = (r_state != BOOT);
    assign w_accept   = r_pc_valid & fetch.imem_ready & ~fetch.stall;
    assign w_redirect = w_active & (fetch.Ctrl_jump | fetch.Ctrl_branch);
    assign w_target   = fetch.Ctrl_jump ? fetch.jumpToWhere : fetch.branchToWhere;

    // Next-state, next-PC and flush-counter selection.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_pc_nxt        = r_pc;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN, FLUSH: begin
                if (w_redirect) begin
                    // Redirects win over stall and back-pressure; a redirect
                    // during FLUSH restarts the flush window.
                    w_pc_nxt        = {w_target[31:2], 2'b00};
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = c_flush_load;
                end else begin
                    if (w_accept) begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                    if (r_state == FLUSH) begin
                        if (r_flush_cnt == 3'd0) begin
                            w_state_nxt = RUN;
                        end else begin
                            w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    // State, PC and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= BOOT;
            r_flush_cnt <= 3'd0;
            r_pc        <= RESET_PC;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_pc        <= w_pc_nxt;
        end
    end

    // Registered status outputs, decoded from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_valid    <= 1'b0;
            r_flush       <= 1'b0;
            r_addr_err    <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_pc_valid    <= (w_state_nxt != BOOT);
            r_flush       <= (w_state_nxt == FLUSH);
            r_addr_err    <= w_redirect & (|w_target[1:0]);
            r_fetch_count <= r_fetch_count + (w_accept ? 32'd1 : 32'd0);
        end
    end

    assign fetch.pc_cur      = r_pc;
    assign fetch.pc_valid    = r_pc_valid;
    assign fetch.flush       = r_flush;
    assign fetch.addr_err    = r_addr_err;
    assign fetch.fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_sequencer
// Brief    : Directed + randomized bench for pc_fetch_sequencer with a
//            cycle-level behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pc_fetch_sequencer;

    localparam logic [31:0] c_reset_pc     = 32'h0000_3000;
    localparam int          c_flush_cycles = 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pc_fetch_sequencer_if bus();

    pc_fetch_sequencer #(
        .RESET_PC     (c_reset_pc),
        .FLUSH_CYCLES (c_flush_cycles)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .fetch (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: "booting" flag plus remaining flush cycles.
    bit          m_boot;
    int          m_rem;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_rem  = 0;
        m_pc   = c_reset_pc;
        m_cnt  = 32'd0;
        m_err  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    bus.pc_cur,      m_pc);
        check({tag, ".valid"}, bus.pc_valid,    {31'd0, !m_boot});
        check({tag, ".flush"}, bus.flush,       {31'd0, m_rem > 0});
        check({tag, ".err"},   bus.addr_err,    {31'd0, m_err});
        check({tag, ".count"}, bus.fetch_count, m_cnt);
    endtask

    // One clock: drive at negedge, advance model at posedge, compare #1 later.
    task automatic step(input string tag, input logic s, input logic r,
                        input logic j, input logic [31:0] jt,
                        input logic b, input logic [31:0] bt);
        logic        acc;
        logic [31:0] tgt;
        @(negedge clk);
        bus.stall         = s;
        bus.imem_ready    = r;
        bus.Ctrl_jump     = j;
        bus.jumpToWhere   = jt;
        bus.Ctrl_branch   = b;
        bus.branchToWhere = bt;
        @(posedge clk);
        acc = !m_boot && r && !s;
        if (m_boot) begin
            m_boot = 1'b0;
            m_err  = 1'b0;
        end else if (j || b) begin
            tgt   = j ? jt : bt;
            m_pc  = tgt & 32'hFFFF_FFFC;
            m_rem = c_flush_cycles;
            m_err = (tgt[1:0] != 2'b00);
        end else begin
            if (acc) m_pc = m_pc + 32'd4;
            if (m_rem > 0) m_rem = m_rem - 1;
            m_err = 1'b0;
        end
        if (acc) m_cnt = m_cnt + 32'd1;
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed mid-cycle.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic idle(input string tag, input logic s);
        step(tag, s, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.stall         = 1'b0;
        bus.imem_ready    = 1'b0;
        bus.Ctrl_jump     = 1'b0;
        bus.jumpToWhere   = 32'd0;
        bus.Ctrl_branch   = 1'b0;
        bus.branchToWhere = 32'd0;
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        // Leave BOOT, then four accepted fetches.
        idle("boot", 1'b0);
        check("boot.pc", bus.pc_cur, 32'h3000);
        for (int i = 0; i < 4; i++) idle("seq", 1'b0);
        check("seq.pc", bus.pc_cur, 32'h3010);
        check("seq.count", bus.fetch_count, 32'd4);

        // Stall holds PC and count.
        for (int i = 0; i < 3; i++) idle("stall", 1'b1);
        check("stall.pc", bus.pc_cur, 32'h3010);
        check("stall.count", bus.fetch_count, 32'd4);

        // Simultaneous jump + branch while stalled: jump wins.
        step("jb", 1'b1, 1'b1, 1'b1, 32'h4000, 1'b1, 32'h5000);
        check("jb.pc", bus.pc_cur, 32'h4000);
        check("jb.flush", bus.flush, 32'd1);
        check("jb.err", bus.addr_err, 32'd0);
        for (int i = 0; i < c_flush_cycles; i++) idle("jbfl", 1'b1);
        check("jbfl.flush_end", bus.flush, 32'd0);

        // Misaligned branch, then re-redirect during flush.
        step("br1", 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h3102);
        check("br1.pc", bus.pc_cur, 32'h3100);
        check("br1.err", bus.addr_err, 32'd1);
        step("br2", 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h3200);
        check("br2.pc", bus.pc_cur, 32'h3200);
        check("br2.err", bus.addr_err, 32'd0);
        for (int i = 0; i < c_flush_cycles - 1; i++) idle("br2fl", 1'b1);
        check("br2fl.flush_held", bus.flush, 32'd1);
        idle("br2fl", 1'b1);
        check("br2fl.flush_end", bus.flush, 32'd0);

        // Wrap at the top of the address space.
        step("wrapj", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
        idle("wrap", 1'b0);
        check("wrap.pc", bus.pc_cur, 32'h0000_0000);

        // Reset mid-flush, then one clock later pc_valid returns.
        step("prerst", 1'b0, 1'b1, 1'b1, 32'h7000, 1'b0, 32'd0);
        do_reset("rst1");
        idle("rst1boot", 1'b0);
        check("rst1boot.valid", bus.pc_valid, 32'd1);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step("rnd",
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 9) == 0,
                     ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : 32'($urandom()),
                     $urandom_range(0, 7) == 0,
                     32'($urandom()));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
